// File: rtl/ps2_pkg.sv
// Shared PS/2 host-side definitions: FSM states, frame layout and command bytes.
package ps2_pkg;

    localparam int unsigned CNT_W      = 21;
    localparam int unsigned SHIFT_W    = 10;
    localparam int unsigned FRAME_CLKS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        XFER,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // Shift order is LSB first: data, then parity, then stop.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    function automatic ps2_frame_t make_frame(input logic [7:0] d);
        ps2_frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^d;
        f.data   = d;
        return f;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes PS2Clk/PS2Data, debounces both to stable levels and flags PS2Clk falls.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic data_level,
    output logic clk_fall
);

    localparam int unsigned RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    // Index 0 = PS2Clk, index 1 = PS2Data.
    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    logic [1:0]       level_q;
    logic [RUN_W-1:0] run_q [2];
    logic [1:0]       flip;
    logic             fall_q;

    // A level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = (sync_q[i] != level_q[i]) && (run_q[i] == RUN_W'(FILTER_LEN - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 2'b11;
            sync_q   <= 2'b11;
            level_q  <= 2'b11;
            run_q[0] <= '0;
            run_q[1] <= '0;
            fall_q   <= 1'b0;
        end else begin
            meta_q <= {ps2_data, ps2_clk};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == level_q[i]) begin
                    run_q[i] <= '0;
                end else if (flip[i]) begin
                    run_q[i]   <= '0;
                    level_q[i] <= sync_q[i];
                end else begin
                    run_q[i] <= run_q[i] + RUN_W'(1);
                end
            end
            fall_q <= flip[0] & level_q[0];
        end
    end

    assign clk_sync   = sync_q[0];
    assign data_sync  = sync_q[1];
    assign data_level = level_q[1];
    assign clk_fall   = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one byte, check ACK.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2Clk_in,
    input  logic       PS2Data_in,
    output logic       PS2Clk_oe,
    output logic       PS2Data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    logic clk_sync;
    logic data_sync;
    logic data_level;
    logic clk_fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (PS2Clk_in),
        .ps2_data   (PS2Data_in),
        .clk_sync   (clk_sync),
        .data_sync  (data_sync),
        .data_level (data_level),
        .clk_fall   (clk_fall)
    );

    ps2_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic               ack_ok_q, ack_ok_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               timeout;
    logic               abort;

    // Shared counter saturates so a stuck device can never wrap it back below the limit.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // A request coinciding with the completion pulse belongs to the old frame.
                if (tx_start && !done_q && !err_q) begin
                    shift_d  = make_frame(tx_data);
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q >= CNT_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end
            end
            RTS: begin
                clk_oe_d  = 1'b0;
                cnt_d     = '0;
                bit_cnt_d = '0;
                state_d   = XFER;
            end
            XFER: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[SHIFT_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'(1);
                    if (bit_cnt_q == 4'(FRAME_CLKS - 2)) begin
                        state_d = ACK;
                    end
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    cnt_d    = '0;
                    ack_ok_d = ~data_level;
                    state_d  = WAIT_IDLE;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d  = ack_ok_q;
                    err_d   = ~ack_ok_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign PS2Clk_oe  = clk_oe_q;
    assign PS2Data_oe = data_oe_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 keyboard clocks frames out of the DUT and ACKs or NACKs them.
module tb_ps2_tx;

    localparam int unsigned INHIBIT = 100;
    localparam int unsigned TIMEOUT = 2000;
    localparam int unsigned FLEN    = 8;
    localparam int          H       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PS2Clk_in, PS2Data_in;
    logic       PS2Clk_oe, PS2Data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    ps2_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PS2Clk_in  (PS2Clk_in),
        .PS2Data_in (PS2Data_in),
        .PS2Clk_oe  (PS2Clk_oe),
        .PS2Data_oe (PS2Data_oe),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device.
    assign PS2Clk_in  = dev_clk  & ~PS2Clk_oe;
    assign PS2Data_in = dev_data & ~PS2Data_oe;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err)  err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bits on the wire after the start bit: d0..d7, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Counts cycles of clock-only inhibit and of request-to-send until the clock is released.
    task automatic measure_inhibit(output int inh, output int rts);
        inh = 0;
        rts = 0;
        for (int i = 0; i < 5 * INHIBIT; i++) begin
            if (!PS2Clk_oe) break;
            if (PS2Data_oe) rts++;
            else            inh++;
            tick(1);
        end
    endtask

    // Device clocks nclk pulses, sampling data on rising edges; glitch_k injects a short low pulse.
    task automatic dev_frame(input bit ack, input int nclk, input int glitch_k, output logic [9:0] bits);
        bits = '0;
        tick(H);
        for (int k = 0; k < nclk && k < 10; k++) begin
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
            bits[k] = PS2Data_in;
            if (k == glitch_k) begin
                tick(5);
                dev_clk  = 1'b0;
                tx_start = 1'b1;
                tx_data  = 8'($urandom);
                tick(1);
                tx_start = 1'b0;
                tick(2);
                dev_clk = 1'b1;
                tick(H - 8);
            end else begin
                tick(H);
            end
        end
        if (nclk >= 11) begin
            dev_data = ack ? 1'b0 : 1'b1;
            tick(H);
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
            tick(H);
            dev_data = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack,
                             input int glitch_k, input bit poke);
        int d0;
        int e0;
        int inh;
        int rts;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        measure_inhibit(inh, rts);
        check($sformatf("%s_inhibit", tag), inh, INHIBIT);
        check($sformatf("%s_rts", tag), rts, 1);
        dev_frame(ack, 11, glitch_k, bits);
        check($sformatf("%s_bits", tag), {22'd0, bits}, {22'd0, model_frame(b)});
        for (int i = 0; i < 200; i++) begin
            if (tx_done || tx_err) break;
            tick(1);
        end
        if (poke) begin
            tx_start = 1'b1;
            tx_data  = 8'($urandom);
            tick(1);
            tx_start = 1'b0;
        end
        tick(20);
        check($sformatf("%s_done", tag), done_cnt - d0, ack ? 1 : 0);
        check($sformatf("%s_err", tag), err_cnt - e0, ack ? 0 : 1);
        check($sformatf("%s_busy", tag), tx_busy, 0);
        check($sformatf("%s_oe", tag), {PS2Clk_oe, PS2Data_oe}, 2'b00);
    endtask

    initial begin
        int inh;
        int rts;
        int cnt;
        int e0;
        int d0;
        logic [9:0] bits;
        logic [9:0] exp_bits;
        logic [7:0] rb;
        bit         rack;

        tick(3);
        check("reset_clk_oe",  PS2Clk_oe, 0);
        check("reset_data_oe", PS2Data_oe, 0);
        check("reset_busy",    tx_busy, 0);
        check("reset_done",    tx_done, 0);
        check("reset_err",     tx_err, 0);
        rst = 1'b0;
        tick(2);

        run_frame("set_leds", ps2_pkg::CMD_SET_LEDS, 1'b1, -1, 1'b0);
        run_frame("byte01",   8'h01, 1'b1, -1, 1'b0);
        run_frame("byte00",   8'h00, 1'b1, -1, 1'b1);
        run_frame("nack",     8'h3C, 1'b0, -1, 1'b0);

        // Device never clocks: abort exactly TIMEOUT cycles after the clock is released.
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'hA5);
        measure_inhibit(inh, rts);
        cnt = 0;
        for (int i = 0; i < 3 * TIMEOUT; i++) begin
            if (tx_err) break;
            tick(1);
            cnt++;
        end
        check("timeout_cycles", cnt, TIMEOUT);
        check("timeout_busy",   tx_busy, 0);
        check("timeout_oe",     {PS2Clk_oe, PS2Data_oe}, 2'b00);
        tick(2);
        check("timeout_err",    err_cnt - e0, 1);
        check("timeout_done",   done_cnt - d0, 0);

        // Reset after four device clocks releases both lines immediately.
        start_tx(ps2_pkg::CMD_RESET);
        measure_inhibit(inh, rts);
        dev_frame(1'b1, 4, -1, bits);
        exp_bits = model_frame(ps2_pkg::CMD_RESET);
        check("partial_bits", {28'd0, bits[3:0]}, {28'd0, exp_bits[3:0]});
        check("pre_rst_busy", tx_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_oe",   {PS2Clk_oe, PS2Data_oe}, 2'b00);
        check("rst_busy", tx_busy, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        run_frame("resend_ff", ps2_pkg::CMD_RESET, 1'b1, -1, 1'b0);

        run_frame("glitch", 8'h96, 1'b1, 4, 1'b0);

        for (int n = 0; n < 4; n++) begin
            rb   = (n == 0) ? ps2_pkg::ACK_BYTE : 8'($urandom);
            rack = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", n), rb, rack, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule
